// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one word fetch at a time to instruction memory and
// buffers returned words in a 2-entry queue presented to decode by valid/ready.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] Instruction_bus_o,
  output logic [6:0]  op_o,
  output logic [31:0] pc_o,
  output logic        misaligned_o
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StDiscard} state_e;

  state_e      state_q, state_d;
  logic [1:0]  occ_q, occ_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0] data0_q, data0_d, data1_q, data1_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        misaligned_q, misaligned_d;

  logic       req;
  logic       pop;
  logic       push;
  logic       outstanding;
  logic [1:0] occ_pop;

  always_comb begin
    req         = (state_q == StReq) && (occ_q != 2'd2);
    pop         = (occ_q != 2'd0) && instr_ready_i && !redirect_i;
    push        = (state_q == StWait) && imem_rvalid_i && !redirect_i;
    // A fetch is in flight past this edge unless its response lands now.
    outstanding = (((state_q == StWait) || (state_q == StDiscard)) && !imem_rvalid_i) ||
                  (req && imem_ready_i);
    occ_pop     = occ_q - {1'b0, pop};

    state_d      = state_q;
    pc0_d        = pc0_q;
    pc1_d        = pc1_q;
    data0_d      = data0_q;
    data1_d      = data1_q;
    fetch_pc_d   = fetch_pc_q;
    misaligned_d = 1'b0;

    if (pop) begin
      pc0_d   = pc1_q;
      data0_d = data1_q;
    end
    if (push) begin
      if (occ_pop == 2'd0) begin
        pc0_d   = fetch_pc_q;
        data0_d = imem_rdata_i;
      end else begin
        pc1_d   = fetch_pc_q;
        data1_d = imem_rdata_i;
      end
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    occ_d = occ_pop + {1'b0, push};

    unique case (state_q)
      StReq: begin
        if (occ_q == 2'd2)     state_d = StHold;
        else if (imem_ready_i) state_d = StWait;
      end
      StWait: begin
        if (imem_rvalid_i) state_d = (occ_d < 2'd2) ? StReq : StHold;
      end
      StHold: begin
        if (occ_d < 2'd2) state_d = StReq;
      end
      StDiscard: begin
        if (imem_rvalid_i) state_d = StReq;
      end
      default: state_d = StReq;
    endcase

    if (redirect_i) begin
      occ_d        = 2'd0;
      fetch_pc_d   = {redirect_pc_i[31:2], 2'b00};
      misaligned_d = (redirect_pc_i[1:0] != 2'b00);
      state_d      = outstanding ? StDiscard : StReq;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StReq;
      occ_q        <= 2'd0;
      pc0_q        <= 32'd0;
      pc1_q        <= 32'd0;
      data0_q      <= 32'd0;
      data1_q      <= 32'd0;
      fetch_pc_q   <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      occ_q        <= occ_d;
      pc0_q        <= pc0_d;
      pc1_q        <= pc1_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      fetch_pc_q   <= fetch_pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_comb begin
    // Gate with reset so no request is seen while reset is held.
    imem_req_o        = req && reset;
    imem_addr_o       = fetch_pc_q;
    instr_valid_o     = (occ_q != 2'd0);
    Instruction_bus_o = instr_valid_o ? data0_q : NOP_WORD;
    op_o              = Instruction_bus_o[6:0];
    pc_o              = instr_valid_o ? pc0_q : 32'd0;
    misaligned_o      = misaligned_q;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Upstream fetch stage of the RISC-V core: owns the program counter, issues word fetches to instruction memory over a request/response handshake, and buffers returned words in a 2-entry queue. It presents one instruction per valid/ready transfer to decode, where `op_o` and `Instruction_bus_o` drive the immediate generator directly. Branch/jump redirects (target = PC + immediate) flush the queue and squash any in-flight fetch.

## Interface
- `RESET_PC`, 32'h0040_0000, first fetch address after reset
- `NOP_WORD`, 32'h0000_0013, value on `Instruction_bus_o` when queue empty

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-low
- `imem_req_o`  out  1  fetch request, held until accepted
- `imem_addr_o`  out  32  fetch byte address, word aligned, stable while `imem_req_o`
- `imem_ready_i`  in  1  memory accepts request this cycle
- `imem_rvalid_i`  in  1  response valid, at least 1 cycle after acceptance
- `imem_rdata_i`  in  32  response word
- `redirect_i`  in  1  branch/jump taken, one-cycle pulse
- `redirect_pc_i`  in  32  redirect target
- `instr_valid_o`  out  1  queue head valid
- `instr_ready_i`  in  1  decode consumes head
- `Instruction_bus_o`  out  32  head instruction
- `op_o`  out  7  `Instruction_bus_o[6:0]`
- `pc_o`  out  32  head instruction address
- `misaligned_o`  out  1  one-cycle pulse: `redirect_pc_i[1:0]` nonzero

## Operation
- FSM states: REQ, WAIT, HOLD, DISCARD. Reset -> REQ.
- REQ: `imem_req_o`=1 if occupancy < 2, else go HOLD. On `imem_ready_i` -> WAIT.
- WAIT: on `imem_rvalid_i`, push {fetch_pc, rdata}, fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0). Next state REQ if occupancy after push and pop < 2, else HOLD.
- HOLD: no request; -> REQ when a pop frees an entry.
- DISCARD: wait for the stale response, drop it (no push, no PC change), -> REQ.
- At most one outstanding fetch. A request is issued only when a queue slot is free, so a response never meets a full queue.
- Redirect (any state, highest priority): flush queue to 0 entries, fetch_pc = {redirect_pc_i[31:2], 2'b00}, `misaligned_o`=1 if low bits nonzero. Next state DISCARD if a fetch is outstanding: WAIT without `imem_rvalid_i` this cycle, or REQ with `imem_ready_i` this cycle. Otherwise REQ.
- Redirect with a response in the same cycle: response dropped, -> REQ.
- Redirect with a head pop in the same cycle: decode is flushed the same cycle, so the transfer is void; no double-count.
- Pop and push in the same cycle: occupancy unchanged, FIFO order preserved.
- `imem_rvalid_i` in REQ or HOLD is ignored. This covers responses still arriving after reset.
- Empty queue: `Instruction_bus_o`=NOP_WORD, `op_o`=7'h13, `pc_o`=0.

## Timing
- Reset values: `imem_req_o`=0, `imem_addr_o`=RESET_PC, `instr_valid_o`=0, `Instruction_bus_o`=NOP_WORD, `op_o`=7'h13, `pc_o`=0, `misaligned_o`=0. Queue empty, fetch_pc=RESET_PC.
- First cycle after `reset` rises: `imem_req_o`=1, `imem_addr_o`=RESET_PC.
- Response in cycle N -> `instr_valid_o`=1 in N+1 (registered queue).
- Next request is asserted the cycle after the response. Peak throughput is 1 instruction per 2 cycles with single-cycle memory.
- Redirect in cycle N -> `instr_valid_o`=0 in N+1. Request to the target is asserted in N+1 if no fetch is outstanding, otherwise the cycle after the stale response.
- `reset` low in any cycle overrides every other input. All state returns to reset values at that edge.

## Test plan
- Reset release, memory always ready, rvalid 1 cycle later, decode always ready -> addresses 0x0040_0000, 0x0040_0004, 0x0040_0008 issued 2 cycles apart. `pc_o` sequence matches, and `op_o` equals each word's [6:0].
- Decode stalled (`instr_ready_i`=0) -> after 2 words queued, `imem_req_o` stays 0 (HOLD). One pop -> request resumes the next cycle; output order preserved.
- Redirect to 0x0040_0100 while WAIT is outstanding -> stale word (e.g. 0x00A00093) never appears. Next request address is 0x0040_0100 after the stale rvalid. Queue empty in the cycle after the redirect.
- Redirect to 0x0040_0102 -> `misaligned_o` pulses 1 cycle, and the fetch address is 0x0040_0100.
- Simultaneous redirect, rvalid, and pop -> queue empty next cycle, rdata dropped, request to the target issued next cycle.
- `reset` low mid-WAIT, then late rvalid after release -> rvalid is ignored, and the first fetch after release is RESET_PC.
